register_file_burst_reader: RTL and testbench



---
 rtl/register_file_burst_reader.sv | 131 +++++++++++++
 tb/tb_register_file_burst_reader.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/register_file_burst_reader.sv
// Burst reader for the async-read register file: walks raddress from base_addr for
// `length` beats and streams each word out on valid/ready with a last flag.
// Optional XOR checksum output is enabled by REGISTER_FILE_BURST_READER_CHECKSUM_EN.
module register_file_burst_reader #(
   parameter int M          = 32,
   parameter int WIDTH      = 8,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  ce,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [ADDR_WIDTH:0]   length,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH-1:0] raddress,
   input  logic [WIDTH-1:0]      rdata,
   output logic [WIDTH-1:0]      m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  m_last
`ifdef REGISTER_FILE_BURST_READER_CHECKSUM_EN
   ,
   output logic [WIDTH-1:0]      checksum
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

   localparam logic [ADDR_WIDTH:0]   M_CNT     = (ADDR_WIDTH+1)'(M);
   localparam logic [ADDR_WIDTH:0]   REM_ONE   = (ADDR_WIDTH+1)'(1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(M-1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
   logic [ADDR_WIDTH:0]   rem_q, rem_d;
   logic [WIDTH-1:0]      data_q, data_d;
   logic                  valid_q, valid_d;
   logic                  last_q, last_d;
   logic                  accept;
   logic                  xfer;
   logic                  free;

   assign xfer = valid_q && m_ready;
   // The output register can be refilled on the same edge it is drained.
   assign free = !valid_q || m_ready;

   always_comb begin
      state_d = state_q;
      raddr_d = raddr_q;
      rem_d   = rem_q;
      data_d  = data_q;
      valid_d = valid_q;
      last_d  = last_q;
      accept  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               accept  = 1'b1;
               raddr_d = ({1'b0, base_addr} >= M_CNT) ? '0 : base_addr;
               rem_d   = (length > M_CNT) ? M_CNT : length;
               state_d = (length == '0) ? S_DONE : S_READ;
            end
         end
         S_READ: begin
            if (free) begin
               data_d  = rdata;
               valid_d = 1'b1;
               last_d  = (rem_q == REM_ONE);
               raddr_d = (raddr_q == ADDR_LAST) ? '0 : raddr_q + ADDR_ONE;
               rem_d   = rem_q - REM_ONE;
               if (rem_q == REM_ONE) state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (xfer) begin
               valid_d = 1'b0;
               last_d  = 1'b0;
               state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         raddr_q <= '0;
         rem_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
      end else if (ce) begin
         state_q <= state_d;
         raddr_q <= raddr_d;
         rem_q   <= rem_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         last_q  <= last_d;
      end
   end

`ifdef REGISTER_FILE_BURST_READER_CHECKSUM_EN
   logic [WIDTH-1:0] csum_q, csum_d;

   always_comb begin
      csum_d = csum_q;
      if (accept)    csum_d = '0;
      else if (xfer) csum_d = csum_q ^ data_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)  csum_q <= '0;
      else if (ce)   csum_q <= csum_d;
   end

   assign checksum = csum_q;
`endif

   assign busy     = (state_q != S_IDLE);
   assign done     = (state_q == S_DONE);
   assign raddress = raddr_q;
   assign m_data   = data_q;
   assign m_valid  = valid_q;
   assign m_last   = last_q;

endmodule

// File: tb/tb_register_file_burst_reader.sv
// Bench for register_file_burst_reader: a beat-queue model predicts busy/done/stream
// outputs every cycle; directed bursts add literal checks on the captured beats.
module tb_register_file_burst_reader;
   localparam int M  = 32;
   localparam int W  = 8;
   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          reset_n, ce, start, m_ready;
   logic [AW-1:0] base_addr;
   logic [AW:0]   length;
   logic          busy, done, m_valid, m_last;
   logic [AW-1:0] raddress;
   logic [W-1:0]  rdata, m_data;
`ifdef REGISTER_FILE_BURST_READER_CHECKSUM_EN
   logic [W-1:0]  checksum;
`endif

   // Register file write port (same-edge write semantics) and async read
   logic [W-1:0]  rf [M];
   logic          we;
   logic [AW-1:0] wa;
   logic [W-1:0]  wd;
   always @(posedge clk) if (we) rf[wa] <= wd;
   assign rdata = rf[raddress];

   always #5 clk = ~clk;

   register_file_burst_reader #(.M(M), .WIDTH(W), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .reset_n(reset_n), .ce(ce), .start(start),
      .base_addr(base_addr), .length(length), .busy(busy), .done(done),
      .raddress(raddress), .rdata(rdata), .m_data(m_data), .m_valid(m_valid),
      .m_ready(m_ready), .m_last(m_last)
`ifdef REGISTER_FILE_BURST_READER_CHECKSUM_EN
      , .checksum(checksum)
`endif
   );

   int vecs = 0;
   int errs = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   typedef struct {logic [W-1:0] d; logic l;} beat_t;
   beat_t        got [$];
   logic [W-1:0] mq  [$];
   logic         m_busy = 0, m_done = 0, primed = 0;
   logic [W-1:0] m_csum = '0;

   // Model: decisions at negedge describe the state after the next rising edge.
   always @(negedge clk) begin
      if (!reset_n) begin
         mq.delete();
         m_busy = 0; m_done = 0; primed = 0; m_csum = '0;
      end else begin
         check("busy", busy, m_busy);
         check("done", done, m_done);
         check("m_valid", m_valid, primed && mq.size() > 0);
         if (m_valid && mq.size() > 0) begin
            check("m_data", m_data, mq[0]);
            check("m_last", m_last, mq.size() == 1);
         end
`ifdef REGISTER_FILE_BURST_READER_CHECKSUM_EN
         if (m_done) check("checksum", checksum, m_csum);
`endif
         if (ce) begin
            if (m_done) begin
               m_done = 0; m_busy = 0;
            end else if (!m_busy) begin
               if (start) begin
                  int n, b;
                  n = (int'(length) > M) ? M : int'(length);
                  b = (int'(base_addr) >= M) ? 0 : int'(base_addr);
                  for (int k = 0; k < n; k++) mq.push_back(rf[(b + k) % M]);
                  m_busy = 1; primed = 0; m_csum = '0;
                  if (n == 0) m_done = 1;
               end
            end else if (!primed) begin
               primed = 1;
            end else if (m_ready) begin
               got.push_back('{d: m_data, l: m_last});
               m_csum ^= mq[0];
               void'(mq.pop_front());
               if (mq.size() == 0) begin primed = 0; m_done = 1; end
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic burst(input int b, input int l);
      start = 1; base_addr = AW'(b); length = (AW+1)'(l);
      step(1);
      start = 0;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (busy && n < budget) begin step(1); n++; end
      check("idle_timeout", busy, 0);
   endtask

   initial begin
      int    pat [4] = '{1, 0, 0, 1};
      int    i;
      logic [M-1:0] seen;
      reset_n = 0; ce = 1; start = 0; m_ready = 1; base_addr = '0; length = '0;
      we = 0; wa = '0; wd = '0;
      #2;
      check("rst_busy", busy, 0);
      check("rst_valid", m_valid, 0);
      check("rst_raddr", raddress, 0);
      check("rst_data", m_data, 0);
`ifdef REGISTER_FILE_BURST_READER_CHECKSUM_EN
      check("rst_csum", checksum, 0);
`endif
      step(1);
      for (int a = 0; a < M; a++) begin
         we = 1; wa = AW'(a); wd = W'(a + 8'h40);
         step(1);
      end
      we = 0;
      reset_n = 1;
      step(2);

      // Wrap with continuous ready
      got.delete();
      burst(30, 4);
      check("lat_valid0", m_valid, 0);
      check("lat_busy", busy, 1);
      step(1);
      check("lat_valid1", m_valid, 1);
      check("lat_data1", m_data, 8'h5E);
      wait_idle(20);
      check("wrap_cnt", got.size(), 4);
      check("wrap_d0", got[0].d, 8'h5E);
      check("wrap_d1", got[1].d, 8'h5F);
      check("wrap_d2", got[2].d, 8'h40);
      check("wrap_d3", got[3].d, 8'h41);
      check("wrap_lastmask", {got[0].l, got[1].l, got[2].l, got[3].l}, 4'b0001);
`ifdef REGISTER_FILE_BURST_READER_CHECKSUM_EN
      check("wrap_csum", checksum, 8'h00);
`endif

      // Backpressure 1,0,0,1,...
      got.delete();
      burst(30, 4);
      i = 0;
      while (busy && i < 60) begin
         m_ready = pat[i % 4][0];
         step(1);
         i++;
      end
      m_ready = 1;
      check("bp_timeout", busy, 0);
      check("bp_cnt", got.size(), 4);
      check("bp_d0", got[0].d, 8'h5E);
      check("bp_d3", got[3].d, 8'h41);
      step(1);

      // Zero length
      got.delete();
      burst(3, 0);
      check("len0_done", done, 1);
      check("len0_valid", m_valid, 0);
      step(1);
      check("len0_done_off", done, 0);
      check("len0_busy_off", busy, 0);
      check("len0_cnt", got.size(), 0);

      // Oversize length clamps to M
      got.delete();
      burst(7, 40);
      wait_idle(80);
      check("len40_cnt", got.size(), M);
      seen = '0;
      for (int k = 0; k < got.size(); k++) begin
         check("len40_data", got[k].d, W'(((7 + k) % M) + 8'h40));
         seen[got[k].d[AW-1:0]] = 1'b1;
      end
      check("len40_cover", seen, {M{1'b1}});

      // ce freeze with a start pulse while busy
      got.delete();
      burst(0, 8);
      step(2);
      ce = 0; start = 1; base_addr = AW'(20); length = (AW+1)'(2);
      step(3);
      ce = 1;
      step(1);
      start = 0;
      wait_idle(40);
      check("ce_cnt", got.size(), 8);
      for (int k = 0; k < got.size(); k++) check("ce_data", got[k].d, W'(8'h40 + k));
      step(3);
      check("ce_no_requeue", busy, 0);

      // Same-edge write during capture
      got.delete();
      burst(5, 1);
      we = 1; wa = AW'(5); wd = 8'hAA;
      step(1);
      we = 0;
      wait_idle(20);
      check("sew_old", got[0].d, 8'h45);
      got.delete();
      burst(5, 1);
      wait_idle(20);
      check("sew_new", got[0].d, 8'hAA);

      // Reset mid-burst
      got.delete();
      burst(3, 6);
      i = 0;
      while (got.size() < 2 && i < 20) begin step(1); i++; end
      check("mid_beats", got.size() >= 2, 1);
      reset_n = 0;
      #1;
      check("mid_busy", busy, 0);
      check("mid_valid", m_valid, 0);
      check("mid_done", done, 0);
      check("mid_raddr", raddress, 0);
      step(2);
      reset_n = 1;
      step(1);
      got.delete();
      burst(0, 1);
      wait_idle(20);
      check("post_cnt", got.size(), 1);
      check("post_data", got[0].d, 8'h40);
      check("post_last", got[0].l, 1);

      step(2);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
